memdata_fifo: RTL and testbench
===============================

Name: memdata_fifo

Overview:
- Parametrised successor to the multicycle datapath's memory data register.
- Captures memory read data and extracts the byte, halfword or word lane selected by the load's address offset, with zero or sign extension.
- Holds results in a DEPTH-entry buffer with valid/ready handshakes, so memory returns and register writeback can be decoupled under stalls.
- Sits between data-memory read output and the writeback mux.

Parameters:
DATA_W, 32, data width in bits; multiple of 16, >=16
DEPTH, 2, buffer entries; power of two, >=2
OFF_W, $clog2(DATA_W/8), byte-offset width (derived, not overridden)
CNT_W, $clog2(DEPTH+1), occupancy count width (derived)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
flush  input  1  synchronous empty of the buffer (pipeline squash)
in_valid  input  1  memory read data present
in_ready  output  1  buffer can accept this cycle
in_data  input  DATA_W  raw memory read word
in_offset  input  OFF_W  byte address offset within word
in_size  input  2  0=byte, 1=halfword, 2=word, 3=word (reserved alias)
in_signed  input  1  1=sign-extend, 0=zero-extend (ignored for word)
out_valid  output  1  head entry available
out_ready  input  1  consumer takes head entry
out_data  output  DATA_W  formatted load value at head
out_misalign  output  1  head entry's access was misaligned
count  output  CNT_W  current occupancy

Behaviour:
- Clock is clk; reset is synchronous, active-high, named reset. Priority: reset > flush > push/pop.
- Reset: count=0, read/write pointers=0, all storage entries=0; out_valid=0, out_data=0, out_misalign=0, in_ready=1 the cycle after the reset edge.
- in_ready = (count < DEPTH). It is registered-state only, with no combinational path from out_ready. A full buffer refuses input even if out_ready=1 that cycle.
- Push when in_valid && in_ready. The formatted value and misalign flag are written at the clock edge; input is not stored raw.
- Pop when out_valid && out_ready; head pointer advances.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Latency: a push into an empty buffer gives out_valid=1 on the next cycle. There is no bypass.
- out_valid = (count != 0). out_data and out_misalign show the head entry when valid and are forced to 0 when empty.
- Head data is stable while out_valid && !out_ready.
- Formatting, where lane k = in_data[8k+7:8k]:
  - byte: lane in_offset, extended to DATA_W.
  - halfword: bytes {2h+1,2h} with h = in_offset>>1 (offset[0] ignored for selection), extended.
  - word/3: in_data unchanged.
  - Extension: in_signed=1 replicates the selected MSB; in_signed=0 fills with zeros.
- Misalign flag = (halfword && in_offset[0]) || (word && in_offset!=0). Data is still stored per the rules above; the flag is informational only.
- flush: count=0, pointers=0. Storage is not cleared. out_valid=0 the next cycle. Push and pop in the flush cycle are discarded.
- Reset or flush mid-stream: all in-flight entries are lost, with no partial pops.
- count never exceeds DEPTH and never underflows. A pop when empty is impossible because out_valid=0.

Test Plan:
1. Reset, then idle → out_valid=0, out_data=0x00000000, count=0, in_ready=1.
2. Push in_data=0x8899AABB with byte/offset 1/signed, then byte/offset 1/unsigned, then half/offset 2/unsigned, then word/offset 0, with out_ready=1 → out_data sequence 0xFFFFFFAA, 0x000000AA, 0x00008899, 0x8899AABB, each appearing one cycle after its push; out_misalign=0 throughout.
3. Half/offset 3 signed on in_data=0x8899AABB → out_data=0xFFFF8899, out_misalign=1. Word/offset 2 → out_data=0x8899AABB, out_misalign=1.
4. out_ready=0, push three entries (DEPTH=2):
   - After two pushes: count=2, in_ready=0, third push held.
   - Raise out_ready: first entry pops, third accepted next cycle.
   - Order preserved; head data stable while stalled.
5. Occupancy 1 with simultaneous push and pop over 8 cycles → count stays 1, pointer wrap shows no data loss, outputs in input order.
6. Occupancy 2, then flush asserted together with in_valid=1 and out_ready=1 → next cycle count=0, out_valid=0, out_data=0, the push is dropped. Repeat with reset in place of flush → same result, plus storage reads 0 after refilling is skipped.

Source files
------------

// File: rtl/memdata_fifo.sv
// Load-data formatter and small buffer: selects the byte/halfword/word lane of a
// memory read, extends it, and queues the result for writeback with valid/ready.
module memdata_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int OFF_W  = $clog2(DATA_W/8),
    parameter int CNT_W  = $clog2(DEPTH+1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OFF_W-1:0]  in_offset,
    input  logic [1:0]        in_size,
    input  logic              in_signed,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_misalign,
    output logic [CNT_W-1:0]  count
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int NBYTES  = DATA_W/8;
    localparam int NHALVES = DATA_W/16;

    logic [7:0]        lanes  [NBYTES];
    logic [15:0]       halves [NHALVES];
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [OFF_W-1:0]  half_idx;
    logic [DATA_W-1:0] fmt_data;
    logic              fmt_misalign;

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic              mis_reg [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              push;
    logic              pop;

    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_lanes
            assign lanes[gi] = in_data[8*gi +: 8];
        end
        for (gi = 0; gi < NHALVES; gi++) begin : g_halves
            assign halves[gi] = in_data[16*gi +: 16];
        end
    endgenerate

    assign half_idx = in_offset >> 1;

    // Offset comparisons are done as an explicit mux so widths that are not
    // powers of two never index past the lane arrays.
    always_comb begin
        byte_sel = '0;
        half_sel = '0;
        for (int k = 0; k < NBYTES; k++) begin
            if (in_offset == OFF_W'(k)) byte_sel = lanes[k];
        end
        for (int k = 0; k < NHALVES; k++) begin
            if (half_idx == OFF_W'(k)) half_sel = halves[k];
        end
    end

    always_comb begin
        fmt_data = in_data;
        case (in_size)
            2'd0: fmt_data = in_signed ? {{(DATA_W-8){byte_sel[7]}}, byte_sel}
                                       : {{(DATA_W-8){1'b0}}, byte_sel};
            2'd1: fmt_data = in_signed ? {{(DATA_W-16){half_sel[15]}}, half_sel}
                                       : {{(DATA_W-16){1'b0}}, half_sel};
            default: fmt_data = in_data;
        endcase
    end

    assign fmt_misalign = ((in_size == 2'd1) && in_offset[0]) ||
                          (in_size[1] && (in_offset != '0));

    assign in_ready  = (count_reg < CNT_W'(DEPTH));
    assign out_valid = (count_reg != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem_reg[k] <= '0;
                mis_reg[k] <= 1'b0;
            end
        end else if (flush) begin
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                mem_reg[wr_ptr_reg] <= fmt_data;
                mis_reg[wr_ptr_reg] <= fmt_misalign;
                wr_ptr_reg          <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign out_data     = out_valid ? mem_reg[rd_ptr_reg] : '0;
    assign out_misalign = out_valid ? mis_reg[rd_ptr_reg] : 1'b0;
    assign count        = count_reg;
endmodule

// File: tb/tb_memdata_fifo.sv
// Directed bench for memdata_fifo (DATA_W=32, DEPTH=2): formatting, handshake,
// stall ordering, pointer wrap, flush and reset.
module tb_memdata_fifo;
    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, in_signed;
    logic        out_valid, out_ready, out_misalign;
    logic [31:0] in_data, out_data;
    logic [1:0]  in_offset, in_size, count;
    int          n_cmp = 0;
    int          n_err = 0;

    memdata_fifo #(.DATA_W(32), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_offset(in_offset), .in_size(in_size), .in_signed(in_signed),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_misalign(out_misalign), .count(count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [1:0] sz,
                         input logic [1:0] off, input logic sg);
        in_valid = v; in_data = d; in_size = sz; in_offset = off; in_signed = sg;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 2'd0, 2'd0, 1'b0);
        step();
        step();
        reset = 1'b0;
        step();
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_mis", {31'b0, out_misalign}, 32'd0);
        chk("rst_count", {30'b0, count}, 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);

        // Lane extraction with the consumer always ready
        out_ready = 1'b1;
        drive(1'b1, 32'h8899AABB, 2'd0, 2'd1, 1'b1); step();
        chk("b1s_valid", {31'b0, out_valid}, 32'd1);
        chk("b1s_data", out_data, 32'hFFFFFFAA);
        chk("b1s_mis", {31'b0, out_misalign}, 32'd0);
        drive(1'b1, 32'h8899AABB, 2'd0, 2'd1, 1'b0); step();
        chk("b1u_data", out_data, 32'h000000AA);
        chk("b1u_count", {30'b0, count}, 32'd1);
        drive(1'b1, 32'h8899AABB, 2'd1, 2'd2, 1'b0); step();
        chk("h2u_data", out_data, 32'h00008899);
        chk("h2u_mis", {31'b0, out_misalign}, 32'd0);
        drive(1'b1, 32'h8899AABB, 2'd2, 2'd0, 1'b1); step();
        chk("w0_data", out_data, 32'h8899AABB);
        chk("w0_mis", {31'b0, out_misalign}, 32'd0);
        drive(1'b1, 32'h8899AABB, 2'd1, 2'd3, 1'b1); step();
        chk("h3s_data", out_data, 32'hFFFF8899);
        chk("h3s_mis", {31'b0, out_misalign}, 32'd1);
        drive(1'b1, 32'h8899AABB, 2'd2, 2'd2, 1'b1); step();
        chk("w2_data", out_data, 32'h8899AABB);
        chk("w2_mis", {31'b0, out_misalign}, 32'd1);
        drive(1'b1, 32'h8899AABB, 2'd3, 2'd0, 1'b1); step();
        chk("w3_data", out_data, 32'h8899AABB);
        chk("w3_mis", {31'b0, out_misalign}, 32'd0);
        drive(1'b1, 32'h000080FF, 2'd0, 2'd0, 1'b0); step();
        chk("b0u_data", out_data, 32'h000000FF);
        drive(1'b1, 32'h7F00FF00, 2'd1, 2'd2, 1'b1); step();
        chk("h2s_pos", out_data, 32'h00007F00);
        drive(1'b0, 32'h0, 2'd0, 2'd0, 1'b0); step();
        chk("drain_valid", {31'b0, out_valid}, 32'd0);
        chk("drain_data", out_data, 32'h0);

        // Stall: fill to DEPTH, third push held back
        out_ready = 1'b0;
        drive(1'b1, 32'h11111111, 2'd2, 2'd0, 1'b0); step();
        chk("st1_count", {30'b0, count}, 32'd1);
        drive(1'b1, 32'h22222222, 2'd2, 2'd0, 1'b0); step();
        chk("st2_count", {30'b0, count}, 32'd2);
        chk("st2_ready", {31'b0, in_ready}, 32'd0);
        chk("st2_head", out_data, 32'h11111111);
        drive(1'b1, 32'h33333333, 2'd2, 2'd0, 1'b0); step();
        chk("st3_count", {30'b0, count}, 32'd2);
        chk("st3_head", out_data, 32'h11111111);
        out_ready = 1'b1; step();
        chk("st4_count", {30'b0, count}, 32'd1);
        chk("st4_head", out_data, 32'h22222222);
        chk("st4_ready", {31'b0, in_ready}, 32'd1);
        step();
        chk("st5_count", {30'b0, count}, 32'd1);
        chk("st5_head", out_data, 32'h33333333);
        drive(1'b0, 32'h0, 2'd0, 2'd0, 1'b0); step();
        chk("st6_count", {30'b0, count}, 32'd0);

        // Occupancy 1 with push+pop every cycle across several pointer wraps
        out_ready = 1'b0;
        drive(1'b1, 32'hA0000000, 2'd2, 2'd0, 1'b0); step();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'hA0000000 + i, 2'd2, 2'd0, 1'b0); step();
            chk("wrap_count", {30'b0, count}, 32'd1);
            chk("wrap_data", out_data, 32'hA0000000 + i);
        end
        drive(1'b0, 32'h0, 2'd0, 2'd0, 1'b0); step();
        chk("wrap_empty", {30'b0, count}, 32'd0);

        // Flush with simultaneous push and pop
        out_ready = 1'b0;
        drive(1'b1, 32'hC1C1C1C1, 2'd2, 2'd0, 1'b0); step();
        drive(1'b1, 32'hC2C2C2C2, 2'd2, 2'd0, 1'b0); step();
        chk("fl_full", {30'b0, count}, 32'd2);
        flush = 1'b1; out_ready = 1'b1;
        drive(1'b1, 32'hC3C3C3C3, 2'd2, 2'd0, 1'b0); step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 2'd0, 2'd0, 1'b0);
        chk("fl_count", {30'b0, count}, 32'd0);
        chk("fl_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_data", out_data, 32'h0);
        step();
        chk("fl_dropped", {30'b0, count}, 32'd0);

        // Same scenario with reset
        out_ready = 1'b0;
        drive(1'b1, 32'hD1D1D1D1, 2'd2, 2'd0, 1'b0); step();
        drive(1'b1, 32'hD2D2D2D2, 2'd2, 2'd0, 1'b0); step();
        chk("rs_full", {30'b0, count}, 32'd2);
        reset = 1'b1; out_ready = 1'b1;
        drive(1'b1, 32'hD3D3D3D3, 2'd2, 2'd0, 1'b0); step();
        reset = 1'b0;
        drive(1'b0, 32'h0, 2'd0, 2'd0, 1'b0);
        chk("rs_count", {30'b0, count}, 32'd0);
        chk("rs_valid", {31'b0, out_valid}, 32'd0);
        chk("rs_data", out_data, 32'h0);
        chk("rs_mis", {31'b0, out_misalign}, 32'd0);
        chk("rs_ready", {31'b0, in_ready}, 32'd1);
        step();
        chk("rs_dropped", {30'b0, count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
